// File: rtl/dec_bin_pkg.sv
// Shared definitions for the decimal <-> binary converter family.
//   N_DIG   : number of packed BCD digits handled by the wide converter
//   BIN_W   : binary result width, enough for 10^N_DIG - 1
//   DI_W    : width of the packed BCD input word
//   state_t : converter FSM encoding (code 2'd3 is unused and returns to IDLE)
//   digit_invalid() : flags a BCD nibble outside 0..9
package dec_bin_pkg;

  localparam int N_DIG = 8;
  localparam int BIN_W = 27;
  localparam int DI_W  = 4 * N_DIG;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic digit_invalid(input logic [3:0] digit);
    return digit > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational decimal multiply-accumulate step: result = acc*10 + digit.
// Ports:
//   acc     in  BIN_W  running binary value
//   digit   in  4      next BCD digit (most significant first)
//   result  out BIN_W  acc*10 + digit
//   invalid out 1      digit is not a legal BCD code (> 9)
// The caller guarantees acc*10 + 9 fits in BIN_W, so no carry-out is kept.
module bcd_mac10
  import dec_bin_pkg::*;
(
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] result,
  output logic             invalid
);

  // x10 as shift-and-add: 8x + 2x.
  assign result  = (acc << 3) + (acc << 1) + BIN_W'(digit);
  assign invalid = digit_invalid(digit);

endmodule

// File: rtl/dec8_to_bin27.sv
// Sequential 8-digit packed-BCD to 27-bit binary converter.
// One digit is folded in per clock (MSD first); a conversion takes
// start + 8 accumulate cycles + 1 result cycle, so ok rises 9 cycles after
// the st sample and a new st can be taken during the ok cycle.
// Ports:
//   clk   in  1   system clock, rising edge
//   rst_n in  1   asynchronous active-low reset
//   st    in  1   start request, only honoured in IDLE
//   DI    in  32  packed BCD, DI[31:28] is the most significant digit
//   BIN   out 27  converted value, held until the next completion
//   ok    out 1   one-cycle completion strobe
//   err   out 1   some captured digit was > 9 (BIN forced to 0), held with BIN
//   busy  out 1   conversion in progress
module dec8_to_bin27
  import dec_bin_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st,
  input  logic [DI_W-1:0]  DI,
  output logic [BIN_W-1:0] BIN,
  output logic             ok,
  output logic             err,
  output logic             busy
);

  state_t            state_reg;
  state_t            state_next;

  logic [2:0]        cnt_reg;
  logic [DI_W-1:0]   dsh_reg;
  logic [BIN_W-1:0]  acc_reg;
  logic              bad_reg;

  logic [BIN_W-1:0]  bin_reg;
  logic              ok_reg;
  logic              err_reg;
  logic              busy_reg;

  // FSM-decoded controls
  logic              load_start;
  logic              run_step;
  logic              finish;

  logic [BIN_W-1:0]  mac_result;
  logic              mac_invalid;

  bcd_mac10 u_mac (
    .acc     (acc_reg),
    .digit   (dsh_reg[DI_W-1 -: 4]),
    .result  (mac_result),
    .invalid (mac_invalid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (st) state_next = RUN;
      RUN:     if (cnt_reg == 3'(N_DIG - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    load_start = 1'b0;
    run_step   = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE:    load_start = st;
      RUN:     run_step   = 1'b1;
      DONE:    finish     = 1'b1;
      default: ;
    endcase
  end

  // Datapath: shadow shift register, accumulator, digit counter, error sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsh_reg <= '0;
      acc_reg <= '0;
      cnt_reg <= '0;
      bad_reg <= 1'b0;
    end else if (load_start) begin
      dsh_reg <= DI;
      acc_reg <= '0;
      cnt_reg <= '0;
      bad_reg <= 1'b0;
    end else if (run_step) begin
      acc_reg <= mac_result;
      dsh_reg <= dsh_reg << 4;
      bad_reg <= bad_reg | mac_invalid;
      cnt_reg <= cnt_reg + 3'd1;
    end
  end

  // Output registers. busy follows the next state so it rises with the
  // start edge and drops on the edge that raises ok.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      ok_reg   <= 1'b0;
      err_reg  <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      ok_reg   <= finish;
      busy_reg <= (state_next != IDLE);
      if (finish) begin
        bin_reg <= bad_reg ? '0 : acc_reg;
        err_reg <= bad_reg;
      end
    end
  end

  assign BIN  = bin_reg;
  assign ok   = ok_reg;
  assign err  = err_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_dec8_to_bin27.sv
// Self-checking bench for dec8_to_bin27: a cycle-level behavioural model
// (decimal value of the captured word, 9-cycle completion) is compared with
// the DUT after every rising edge, plus directed literal checks.
module tb_dec8_to_bin27;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st = 1'b0;
  logic [31:0] DI = '0;
  logic [26:0] BIN;
  logic        ok;
  logic        err;
  logic        busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dec8_to_bin27 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .st    (st),
    .DI    (DI),
    .BIN   (BIN),
    .ok    (ok),
    .err   (err),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Decimal value of a packed BCD word: sum of digit * 10^position.
  function automatic void bcd_value(input logic [31:0] w, output logic [26:0] v, output logic bad);
    int unsigned sum;
    int unsigned scale;
    logic [3:0]  nib;
    sum = 0;
    scale = 1;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      nib = w[4*k +: 4];
      if (nib > 4'd9) bad = 1'b1;
      sum += nib * scale;
      scale *= 10;
    end
    v = bad ? 27'd0 : 27'(sum);
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int          m_phase = 0;   // 0 idle, 1..9 cycles since the accepted start
  logic [26:0] m_val = '0;
  logic        m_bad = 1'b0;
  logic [26:0] m_bin = '0;
  logic        m_err = 1'b0;
  logic        m_ok = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase = 0;
        m_bin = '0;
        m_err = 1'b0;
        m_ok = 1'b0;
      end else begin
        m_ok = 1'b0;
        if (m_phase == 0) begin
          if (st) begin
            bcd_value(DI, m_val, m_bad);
            m_phase = 1;
          end
        end else if (m_phase == 9) begin
          m_bin = m_val;
          m_err = m_bad;
          m_ok = 1'b1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
      #1;
      check("cyc_ok", ok, m_ok);
      check("cyc_busy", busy, m_phase != 0);
      check("cyc_bin", BIN, m_bin);
      check("cyc_err", err, m_err);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic run_conv(input logic [31:0] di, input logic [26:0] exp_bin, input logic exp_err);
    int lat;
    int busy_n;
    bit got;
    lat = 0;
    busy_n = 0;
    got = 0;
    @(negedge clk);
    DI = di;
    st = 1'b1;
    @(posedge clk);
    #1;
    if (busy) busy_n++;
    @(negedge clk);
    st = 1'b0;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk);
      #1;
      if (ok) begin
        got = 1;
        lat = i;
      end else if (busy) begin
        busy_n++;
      end
    end
    check("latency", lat, 9);
    check("busy_cycles", busy_n, 9);
    check("bin", BIN, exp_bin);
    check("err", err, exp_err);
    $display("conv DI=%08h BIN=%07h err=%0b lat=%0d", di, BIN, err, lat);
    @(posedge clk);
    #1;
    check("ok_width", ok, 1'b0);
  endtask

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] b;
    int unsigned x;
    b = '0;
    x = v;
    for (int k = 0; k < 8; k++) begin
      b[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return b;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int n_ok;
    int prev;
    logic [26:0] bin_at;
    int unsigned v;
    logic [31:0] w;

    repeat (3) @(negedge clk);
    check("rst_bin", BIN, 27'd0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;

    run_conv(32'h12345678, 27'h0BC614E, 1'b0);
    run_conv(32'h99999999, 27'h5F5E0FF, 1'b0);
    run_conv(32'h00000000, 27'd0, 1'b0);
    run_conv(32'h0000000A, 27'd0, 1'b1);
    run_conv(32'h00000042, 27'd42, 1'b0);

    // DI change and extra st during RUN are ignored
    @(negedge clk);
    DI = 32'h00001234;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (2) @(negedge clk);
    DI = 32'h99999999;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    n_ok = 0;
    bin_at = '0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (ok) begin
        n_ok++;
        bin_at = BIN;
      end
    end
    check("midrun_ok_count", n_ok, 1);
    check("midrun_bin", bin_at, 27'd1234);
    $display("midrun DI=00001234 BIN=%0d oks=%0d", bin_at, n_ok);

    // level-held st: one completion every 10 cycles
    @(negedge clk);
    DI = 32'h00000005;
    st = 1'b1;
    n_ok = 0;
    prev = -1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (ok) begin
        n_ok++;
        if (prev >= 0) check("held_gap", i - prev, 10);
        else check("held_first", i, 9);
        prev = i;
      end
    end
    check("held_ok_count", n_ok, 5);
    $display("held st oks=%0d", n_ok);
    @(negedge clk);
    st = 1'b0;
    repeat (12) @(negedge clk);

    // asynchronous reset in the middle of a conversion
    @(negedge clk);
    DI = 32'h87654321;
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_bin", BIN, 27'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_ok", ok, 1'b0);
    $display("async reset mid-conversion BIN=%0h busy=%0b", BIN, busy);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_conv(32'h00000007, 27'd7, 1'b0);

    // round-trip of random 24-bit values encoded as BCD
    for (int n = 0; n < 1500; n++) begin
      v = $urandom_range(0, 24'hFFFFFF);
      run_conv(to_bcd(v), 27'(v), 1'b0);
    end

    // random free-running traffic, checked by the per-cycle model
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      st = ($urandom % 4) == 0;
      for (int k = 0; k < 8; k++) begin
        if (($urandom % 8) == 0) w[4*k +: 4] = 4'($urandom_range(10, 15));
        else w[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      DI = w;
    end
    @(negedge clk);
    st = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
